// File: rtl/messbauer_diff_discriminator_generator.sv
// messbauer_diff_discriminator_generator: per-channel bursts of lower/upper discriminator test impulses.
// Outputs are registered copies of the FSM state, so they trail the state by one cycle.
module messbauer_diff_discriminator_generator #(
  parameter int LOWER_THRESHOLD_DURATION = 3,
  parameter int UPPER_THRESHOLD_DURATION = 1,
  parameter int IMPULSES_PAUSE           = 10,
  parameter int IMPULSES_PER_CHANNEL     = 16,
  parameter int CHANNEL_NUMBER           = 512,
  parameter int CHANNEL_INDEX_WIDTH      = 9
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  input  logic                           channel,
  input  logic                           enable,
  input  logic [7:0]                     sel_count,
  input  logic                           clear_overrun,
  output logic                           lower_threshold,
  output logic                           upper_threshold,
  output logic                           busy,
  output logic [CHANNEL_INDEX_WIDTH-1:0] channel_index,
  output logic                           frame_done,
  output logic                           overrun
);
  typedef enum logic [1:0] {IDLE, PULSE, PAUSE} state_t;
  localparam logic [7:0] IPC = 8'(IMPULSES_PER_CHANNEL);
  localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_CH = CHANNEL_INDEX_WIDTH'(CHANNEL_NUMBER - 1);
  state_t state, next;
  logic [1:0] sync;
  logic sync_d, rise, pulse_end, pause_end, burst_end, start;
  logic [31:0] cnt;
  logic [7:0] imp, sel_lat;
  assign rise      = sync[1] & ~sync_d;
  assign pulse_end = state == PULSE && cnt == 32'(LOWER_THRESHOLD_DURATION - 1);
  assign pause_end = state == PAUSE && cnt == 32'(IMPULSES_PAUSE - 1);
  assign burst_end = pause_end && imp == IPC - 8'd1;
  assign start     = state == IDLE && rise && enable;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? PULSE : IDLE;
      PULSE:   next = pulse_end ? PAUSE : PULSE;
      PAUSE:   next = pause_end ? (burst_end ? IDLE : PULSE) : PAUSE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= next;
  end
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sync            <= '0;
      sync_d          <= 1'b0;
      cnt             <= '0;
      imp             <= '0;
      sel_lat         <= '0;
      lower_threshold <= 1'b0;
      upper_threshold <= 1'b0;
      busy            <= 1'b0;
      channel_index   <= '0;
      frame_done      <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      sync            <= {sync[0], channel};
      sync_d          <= sync[1];
      cnt             <= (state == IDLE || next != state) ? '0 : cnt + 32'd1;
      imp             <= state == IDLE ? 8'd0 : pause_end ? imp + 8'd1 : imp;
      sel_lat         <= start ? (sel_count > IPC ? IPC : sel_count) : sel_lat;
      lower_threshold <= state == PULSE;
      // upper rides cycles 2..UPPER+1 of a rejected impulse, always inside the lower pulse
      upper_threshold <= state == PULSE && imp >= sel_lat && cnt != 32'd0
                         && cnt <= 32'(UPPER_THRESHOLD_DURATION);
      busy            <= state != IDLE;
      channel_index   <= burst_end ? (channel_index == LAST_CH ? '0 : channel_index + 1'b1) : channel_index;
      frame_done      <= burst_end && channel_index == LAST_CH;
      overrun         <= (rise && state != IDLE) ? 1'b1 : clear_overrun ? 1'b0 : overrun;
    end
  end
endmodule
